// File: rtl/cla_mult_pkg.sv
// Shared types and constants for the sequential shift-and-add multiplier.
package cla_mult_pkg;

  // Number of add/shift iterations for a 16-bit multiplier operand.
  localparam int ITER  = 16;
  // Counter width; wide enough to hold 0..ITER-1 with headroom.
  localparam int CNT_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage : cla_mult_pkg

// File: rtl/cla_mult_seq_cla16.sv
// 16-bit carry-lookahead adder: four 4-bit lookahead groups with a
// second-level lookahead across the group generate/propagate terms.
module CLA_16bit (
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        cin,
  output logic [15:0] S,
  output logic        cout
);

  logic [15:0] g;
  logic [15:0] p;
  logic [16:0] c;
  logic [3:0]  gg;
  logic [3:0]  gp;
  logic [4:0]  gc;

  // Bit and group generate/propagate, group carries, then in-group carries.
  always_comb begin
    g  = A & B;
    p  = A ^ B;
    gg = '0;
    gp = '0;
    gc = '0;
    c  = '0;
    for (int k = 0; k < 4; k++) begin
      gg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      gp[k] = &p[4*k +: 4];
    end
    gc[0] = cin;
    for (int k = 0; k < 4; k++) begin
      gc[k+1] = gg[k] | (gp[k] & gc[k]);
    end
    for (int k = 0; k < 4; k++) begin
      c[4*k]   = gc[k];
      c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & gc[k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
    end
    c[16] = gc[4];
    S     = p ^ c[15:0];
    cout  = c[16];
  end

endmodule : CLA_16bit

// File: rtl/cla_mult_seq.sv
// Multi-cycle unsigned 16x16->32 shift-and-add multiplier built around a
// single CLA_16bit. One conditional add plus one right shift per cycle.
//
// Handshake: start is accepted only on an edge where ready=1 (IDLE).
// done is a one-cycle pulse in DONE; product is registered and holds the
// last result until the next completion (0 after reset). All outputs come
// from registers or decode of the state register only.
module cla_mult_seq
  import cla_mult_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output state_e             dbg_state
);

  if (WIDTH != 16) begin : g_bad_width
    $error("cla_mult_seq: WIDTH must be 16 to match CLA_16bit");
  end

  localparam logic [CNT_W-1:0] LAST = CNT_W'(ITER - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [15:0]      m_q, m_d;
  logic [15:0]      hi_q, hi_d;
  logic [15:0]      lo_q, lo_d;
  logic [31:0]      product_q, product_d;

  logic [15:0]      cla_b;
  logic [15:0]      cla_sum;
  logic             cla_cout;

  // Add the multiplicand only when the current multiplier bit is set.
  assign cla_b = lo_q[0] ? m_q : 16'h0000;

  CLA_16bit u_cla (
    .A    (hi_q),
    .B    (cla_b),
    .cin  (1'b0),
    .S    (cla_sum),
    .cout (cla_cout)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: 16 RUN iterations, then a single DONE cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (count_q == LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode straight from the state register.
  always_comb begin
    ready = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    case (state_q)
      IDLE:    ready = 1'b1;
      RUN:     busy  = 1'b1;
      DONE:    done  = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  assign product   = product_q;
  assign dbg_state = state_q;

  // Datapath next values: operand capture, add-and-shift with the carry
  // kept as the new HI[15], and the product latched on the final iteration.
  always_comb begin
    m_d       = m_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    count_d   = count_q;
    product_d = product_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          m_d     = a;
          lo_d    = b;
          hi_d    = 16'h0000;
          count_d = '0;
        end
      end
      RUN: begin
        hi_d    = {cla_cout, cla_sum[15:1]};
        lo_d    = {cla_sum[0], lo_q[15:1]};
        count_d = count_q + 1'b1;
        if (count_q == LAST) product_d = {hi_d, lo_d};
      end
      default: ;
    endcase
  end

  // Datapath registers; reset discards any partial result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      count_q   <= '0;
      product_q <= '0;
    end else begin
      m_q       <= m_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      count_q   <= count_d;
      product_q <= product_d;
    end
  end

endmodule : cla_mult_seq

// File: doc/cla_mult_seq.md
Name: cla_mult_seq

Overview:
Multi-cycle unsigned 16x16->32 shift-and-add multiplier. It sequences a single instance of the team's 16-bit carry-lookahead adder, CLA_16bit, performing one conditional add and one shift per cycle. It is used wherever a multiply is needed without a dedicated array multiplier. Handshake: start/ready in, one-cycle done pulse out.

Parameters:
WIDTH, 16, operand width; fixed to 16 to match CLA_16bit; any other value is a synthesis-time error.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only while ready=1
a  input  16  multiplicand; captured on accepted start
b  input  16  multiplier; captured on accepted start
ready  output  1  high in IDLE only
busy  output  1  high in RUN only
done  output  1  one-cycle pulse; product valid
product  output  32  result; held from done until the next accepted start

Behaviour:
- Reset (async, rst=1): state=IDLE, ready=1, busy=0, done=0, product=0, all internal registers=0, count=0.
- Registers: M[15:0] holds the multiplicand; HI[15:0] is the accumulator; LO[15:0] holds the multiplier shifting into the low product bits; count[4:0].
- FSM states: IDLE, RUN, DONE.
- IDLE: ready=1. On an edge with start=1: M<=a, LO<=b, HI<=0, count<=0, go to RUN. If start=0, stay in IDLE.
- RUN: busy=1. The CLA is driven with A=HI, B=(LO[0] ? M : 0), cin=0. Each edge:
  - {HI,LO} <= {cout, S, LO} >> 1, i.e. HI<={cout,S[15:1]} and LO<={S[0],LO[15:1]}.
  - count<=count+1.
  - On the edge where count==15 (the 16th iteration), go to DONE.
- DONE: done=1 for exactly one cycle; product={HI,LO}. Next edge returns to IDLE unconditionally.
- Latency: start accepted at edge k; done is high in the cycle following edge k+16, i.e. 17 cycles from start to done.
- Minimum spacing between accepted starts is 18 cycles.
- start is ignored while in RUN or DONE. a and b may change freely after acceptance.
- product holds its value through IDLE and updates only on entry to DONE. Outside DONE, product equals the last result (0 after reset).
- The CLA cout must be captured as HI[15]. The intermediate sum can reach 17 bits and must not be truncated.
- Reset asserted mid-RUN: immediate return to IDLE, the partial result is discarded, product=0. No done pulse is issued.
- Edge cases:
  - Operand 0 in either position gives product 0 after the full 16 cycles; there is no early termination.
  - 0xFFFF*0xFFFF=0xFFFE0001 with no overflow.
- Outputs are registered, or decoded purely from the state register; there is no combinational path from start to any output.

Decomposition:
- Package cla_mult_pkg holds:
  - the state enum typedef (IDLE, RUN, DONE);
  - constant ITER=16;
  - constant CNT_W=5.
- Sub-module: the existing CLA_16bit is instantiated once, unmodified. The FSM, counter and shift datapath stay in cla_mult_seq; no further sub-modules.

Test Plan:
- Basic multiply: reset, then a=3, b=5, start pulse. Required: ready=0 next cycle, busy=1 for 16 cycles, done=1 exactly 17 cycles after the start edge, product=0x0000000F. ready=1 on the following cycle.
- Carry propagation: a=0xFFFF, b=0xFFFF -> product=0xFFFE0001. a=0x8000, b=0x0002 -> product=0x00010000. Both confirm cout is captured.
- Start while busy ignored: start with a=7, b=9. At cycle 5 of RUN, assert start with a=2, b=2. Required: one done only, product=0x0000003F, no second run.
- Async reset mid-operation: start a=0x1234, b=0x5678, assert rst at RUN cycle 8 (not clock-aligned). Required: outputs immediately ready=1, busy=0, done=0, product=0. No done afterward until a new start.
- Hold and zero: after a=0, b=0x1234 -> product=0 at done. Product is held unchanged for 10 idle cycles, then updates on the next done.
- Random regression: 100 random a, b pairs, back-to-back at minimum spacing. Each done's product must equal a*b (32-bit); stop on the first mismatch and print operands, expected and actual.
